// File: rtl/port_bus_arbiter.sv
// -----------------------------------------------------------------------------
// port_bus_arbiter
//
// Two-master round-robin arbiter in front of a single shared peripheral port
// bus (PORT_ID / WRITE_STROBE / READ_STROBE / OUT_PORT / IN_PORT).
//
// Every transaction has a fixed shape:
//   IDLE   -> sample req, pick a winner, latch its we/port_sel/wdata
//   SETUP  -> PORT_ID and OUT_PORT valid, strobes low (address setup)
//   STROBE -> one strobe high for one cycle; read data captured at its end
//   ACK    -> one-cycle ack pulse to the winner, rdata valid
//   GAP    -> STROBE_GAP idle cycles (skipped when STROBE_GAP = 0)
//
// Optional feature: define ARB_PORT_CHECK_EN to block accesses to ports above
// 7. A blocked access still runs through SETUP/STROBE/ACK and acks the master,
// but no strobe reaches the bus and rdata reads back 0x00.
// -----------------------------------------------------------------------------
module port_bus_arbiter #(
    parameter int unsigned STROBE_GAP = 1  // legal range 0..7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [7:0]  port_sel,
    input  logic [15:0] wdata,
    output logic [1:0]  ack,
    output logic [7:0]  rdata,
    output logic [3:0]  PORT_ID,
    output logic        WRITE_STROBE,
    output logic        READ_STROBE,
    output logic [7:0]  OUT_PORT,
    input  logic [7:0]  IN_PORT
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        ACK    = 3'd3,
        GAP    = 3'd4
    } state_t;

    // GAP is entered with STROBE_GAP-1 and left when the counter reaches 0,
    // so it lasts exactly STROBE_GAP cycles.
    localparam bit       HAS_GAP  = (STROBE_GAP != 0);
    localparam logic [2:0] GAP_LOAD = HAS_GAP ? 3'(STROBE_GAP - 1) : 3'd0;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] gap_cnt;
    logic [2:0] gap_cnt_nxt;

    // last_grant doubles as the owner of the transaction in flight: it is
    // updated on every grant and nothing else changes it until the next one.
    logic       last_grant;
    logic       grant;
    logic       winner_nxt;
    logic       we_l;
    logic       port_ok;

    // -------------------------------------------------------------------------
    // Port range check on the latched target (PORT_ID is the latched port for
    // the whole SETUP..ACK window).
    // -------------------------------------------------------------------------
`ifdef ARB_PORT_CHECK_EN
    assign port_ok = ~PORT_ID[3];
`else
    assign port_ok = 1'b1;
`endif

    // Arbitration: single requester always wins; on contention the master
    // that was not granted last time wins.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no
        // path can leave it unassigned and infer a latch.
        grant      = 1'b0;
        winner_nxt = last_grant;
        if (state == IDLE && req != 2'b00) begin
            grant = 1'b1;
            unique case (req)
                2'b01:   winner_nxt = 1'b0;
                2'b10:   winner_nxt = 1'b1;
                default: winner_nxt = ~last_grant;
            endcase
        end
    end

    // Next-state logic and gap counter.
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = STROBE;
            end
            STROBE: begin
                state_nxt = ACK;
            end
            ACK: begin
                if (HAS_GAP) begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = GAP_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == 3'd0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 3'd1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                gap_cnt_nxt = 3'd0;
            end
        endcase
    end

    // Bus strobes and ack decode straight from the registered state, so they
    // are zero in every state other than STROBE / ACK and at most one is set.
    always_comb begin
        WRITE_STROBE = 1'b0;
        READ_STROBE  = 1'b0;
        ack          = 2'b00;
        if (state == STROBE && port_ok) begin
            WRITE_STROBE = we_l;
            READ_STROBE  = ~we_l;
        end
        if (state == ACK) begin
            ack = last_grant ? 2'b10 : 2'b01;
        end
    end

    // State register, grant latch, bus address/data registers and read capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state is written with non-blocking assignments
            // so every register samples pre-edge values regardless of order.
            state      <= IDLE;
            gap_cnt    <= 3'd0;
            last_grant <= 1'b1;
            we_l       <= 1'b0;
            PORT_ID    <= 4'd0;
            OUT_PORT   <= 8'd0;
            rdata      <= 8'd0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;

            // The winner's request fields are frozen here; later changes on
            // req/we/port_sel/wdata cannot reach the transaction in flight.
            if (grant) begin
                last_grant <= winner_nxt;
                we_l       <= we[winner_nxt];
                PORT_ID    <= winner_nxt ? port_sel[7:4] : port_sel[3:0];
                OUT_PORT   <= winner_nxt ? wdata[15:8]   : wdata[7:0];
            end

            // Read data is sampled at the end of the strobe cycle; writes and
            // blocked accesses return zero.
            if (state == STROBE) begin
                rdata <= (!we_l && port_ok) ? IN_PORT : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_port_bus_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for port_bus_arbiter.
//
// The reference model is transaction level: a grant at cycle g means SETUP at
// g+1, STROBE at g+2, ACK at g+3, and the arbiter samples requests again at
// g+4+STROBE_GAP. Expected bus values are derived from those offsets.
// Cycle numbers count clock periods; after do_reset cycle 0 is the first IDLE.
// -----------------------------------------------------------------------------
module tb_port_bus_arbiter;

    localparam int G = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [7:0]  port_sel;
    logic [15:0] wdata;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic [3:0]  PORT_ID;
    logic        WRITE_STROBE;
    logic        READ_STROBE;
    logic [7:0]  OUT_PORT;
    logic [7:0]  IN_PORT;

    always #5 clk = ~clk;

    port_bus_arbiter #(.STROBE_GAP(G)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .we           (we),
        .port_sel     (port_sel),
        .wdata        (wdata),
        .ack          (ack),
        .rdata        (rdata),
        .PORT_ID      (PORT_ID),
        .WRITE_STROBE (WRITE_STROBE),
        .READ_STROBE  (READ_STROBE),
        .OUT_PORT     (OUT_PORT),
        .IN_PORT      (IN_PORT)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model state ----------------
    int         cyc;
    int         g_cyc;
    int         next_sample;
    bit         last;
    bit         win;
    bit         m_we;
    logic [3:0] m_port;
    logic [7:0] m_wd;
    logic [7:0] m_cap;
    logic [3:0] exp_port_id;
    logic [7:0] exp_out;
    logic       exp_ws;
    logic       exp_rs;
    logic [1:0] exp_ack;
    bit         exp_rd_valid;

    // ---------------- observation log ----------------
    int         ack_cyc_q[$];
    logic [1:0] ack_val_q[$];
    int         ws_q[$];
    int         rs_q[$];

    function automatic bit blocked(input logic [3:0] p);
`ifdef ARB_PORT_CHECK_EN
        return (p > 4'd7);
`else
        return 1'b0;
`endif
    endfunction

    task automatic clear_log();
        ack_cyc_q.delete();
        ack_val_q.delete();
        ws_q.delete();
        rs_q.delete();
    endtask

    // Model update from the inputs present during cycle cyc.
    task automatic model_pre();
        if (reset) begin
            g_cyc       = -100;
            next_sample = cyc + 1;
            last        = 1'b1;
            exp_port_id = 4'd0;
            exp_out     = 8'd0;
            m_cap       = 8'd0;
        end else begin
            if (cyc >= next_sample && req != 2'b00) begin
                if (req == 2'b11) win = ~last;
                else              win = req[1];
                last        = win;
                m_we        = we[win];
                m_port      = win ? port_sel[7:4] : port_sel[3:0];
                m_wd        = win ? wdata[15:8]   : wdata[7:0];
                g_cyc       = cyc;
                next_sample = cyc + 4 + G;
            end
            if (cyc == g_cyc + 2) begin
                m_cap = (m_we || blocked(m_port)) ? 8'h00 : IN_PORT;
            end
        end
    endtask

    // Expected outputs for the cycle just entered.
    task automatic model_post();
        int off;
        off          = cyc - g_cyc;
        exp_ws       = 1'b0;
        exp_rs       = 1'b0;
        exp_ack      = 2'b00;
        exp_rd_valid = 1'b0;
        if (off >= 1 && off <= 3) begin
            exp_port_id = m_port;
            exp_out     = m_wd;
        end
        if (off == 2 && !blocked(m_port)) begin
            exp_ws = m_we;
            exp_rs = ~m_we;
        end
        if (off == 3) begin
            exp_ack      = win ? 2'b10 : 2'b01;
            exp_rd_valid = 1'b1;
        end
    endtask

    // One clock: update model, cross the edge, sample #1 later, log events.
    task automatic step();
        model_pre();
        @(posedge clk);
        #1;
        cyc++;
        model_post();
        if (ack != 2'b00) begin
            ack_cyc_q.push_back(cyc);
            ack_val_q.push_back(ack);
        end
        if (WRITE_STROBE) ws_q.push_back(cyc);
        if (READ_STROBE)  rs_q.push_back(cyc);
    endtask

    task automatic idle_inputs();
        req      = 2'b00;
        we       = 2'($urandom);
        port_sel = 8'($urandom);
        wdata    = 16'($urandom);
        IN_PORT  = 8'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        reset       = 1'b0;
        cyc         = 0;
        next_sample = 0;
        g_cyc       = -100;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cyc = 0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req      = 2'($urandom);
            we       = 2'($urandom);
            port_sel = 8'($urandom);
            wdata    = 16'($urandom);
            IN_PORT  = 8'($urandom);
            step();
            n_checks++;
            if ({ack, WRITE_STROBE, READ_STROBE} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_ctrl: got ack=%b ws=%b rs=%b, expected all 0", ack, WRITE_STROBE, READ_STROBE);
            end
            n_checks++;
            if ({PORT_ID, OUT_PORT, rdata} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_data: got PORT_ID=%h OUT_PORT=%h rdata=%h, expected 0", PORT_ID, OUT_PORT, rdata);
            end
        end
        reset       = 1'b0;
        cyc         = 0;
        next_sample = 0;
        g_cyc       = -100;
    endtask

    task automatic test_write();
        do_reset();
        clear_log();
        req = 2'b01; we = 2'b01; port_sel = 8'hE3; wdata = 16'h5AA5;
        step();                                   // cycle 1: SETUP
        req = 2'b00; we = 2'b10; port_sel = 8'h7C; wdata = 16'h1234;
        n_checks++;
        if (PORT_ID !== 4'd3 || OUT_PORT !== 8'hA5 || WRITE_STROBE !== 1'b0) begin
            n_fail++;
            $display("FAIL write_setup: got PORT_ID=%h OUT_PORT=%h ws=%b, expected 3 a5 0", PORT_ID, OUT_PORT, WRITE_STROBE);
        end
        step();                                   // cycle 2: STROBE
        n_checks++;
        if (WRITE_STROBE !== 1'b1 || READ_STROBE !== 1'b0 || PORT_ID !== 4'd3 || OUT_PORT !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_strobe: got ws=%b rs=%b PORT_ID=%h OUT_PORT=%h, expected 1 0 3 a5", WRITE_STROBE, READ_STROBE, PORT_ID, OUT_PORT);
        end
        step();                                   // cycle 3: ACK
        n_checks++;
        if (ack !== 2'b01 || rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL write_ack: got ack=%b rdata=%h, expected 01 00", ack, rdata);
        end
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (ws_q.size() != 1 || ws_q[0] != 2 || rs_q.size() != 0) begin
            n_fail++;
            $display("FAIL write_strobe_count: got %0d write / %0d read strobes, expected one write strobe at cycle 2", ws_q.size(), rs_q.size());
        end
    endtask

    task automatic test_read();
        do_reset();
        clear_log();
        req = 2'b10; we = 2'b01; port_sel = 8'h5B; wdata = 16'($urandom);
        step();                                   // cycle 1
        req = 2'b00; we = 2'b11; port_sel = 8'hA0; IN_PORT = 8'h99;
        step();                                   // cycle 2: STROBE
        IN_PORT = 8'h3C;
        n_checks++;
        if (READ_STROBE !== 1'b1 || WRITE_STROBE !== 1'b0 || PORT_ID !== 4'd5) begin
            n_fail++;
            $display("FAIL read_strobe: got rs=%b ws=%b PORT_ID=%h, expected 1 0 5", READ_STROBE, WRITE_STROBE, PORT_ID);
        end
        step();                                   // cycle 3: ACK
        IN_PORT = 8'hFF;
        n_checks++;
        if (ack !== 2'b10 || rdata !== 8'h3C) begin
            n_fail++;
            $display("FAIL read_ack: got ack=%b rdata=%h, expected 10 3c", ack, rdata);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_contention();
        int n;
        n = 3 + 2 * (4 + G) + 2;
        do_reset();
        clear_log();
        req = 2'b11; we = 2'b11; port_sel = 8'h21; wdata = 16'h00FF;
        for (int i = 0; i < n; i++) step();
        req = 2'b00;
        n_checks++;
        if (ack_cyc_q.size() < 3) begin
            n_fail++;
            $display("FAIL contention_count: got %0d acks, expected at least 3", ack_cyc_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (ack_cyc_q[k] != 3 + k * (4 + G) || ack_val_q[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL contention_ack%0d: got ack=%b at cycle %0d, expected %b at cycle %0d",
                             k, ack_val_q[k], ack_cyc_q[k], (k % 2 == 0) ? 2'b01 : 2'b10, 3 + k * (4 + G));
                end
            end
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 2'b01; we = 2'b01; port_sel = 8'h04; wdata = 16'h0077;
        step();                                   // cycle 1
        req = 2'b00;
        step();                                   // cycle 2: STROBE
        n_checks++;
        if (WRITE_STROBE !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: got ws=%b, expected 1", WRITE_STROBE);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({ack, WRITE_STROBE, READ_STROBE, PORT_ID, OUT_PORT, rdata} !== 24'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ack=%b ws=%b rs=%b PORT_ID=%h OUT_PORT=%h rdata=%h, expected all 0",
                     ack, WRITE_STROBE, READ_STROBE, PORT_ID, OUT_PORT, rdata);
        end
        clear_log();
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (ack_val_q.size() != 0 || ws_q.size() != 0 || rs_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got %0d acks %0d strobes after abort, expected 0",
                     ack_val_q.size(), ws_q.size() + rs_q.size());
        end
        req = 2'b10; we = 2'b00; port_sel = 8'h60; IN_PORT = 8'h42;
        step();
        req = 2'b00;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (ack_val_q.size() != 1 || ack_val_q[0] !== 2'b10 || rs_q.size() != 1) begin
            n_fail++;
            $display("FAIL midreset_recover: got %0d acks %0d read strobes, expected one ack=10 and one read strobe",
                     ack_val_q.size(), rs_q.size());
        end
    endtask

    task automatic test_port_check();
        do_reset();
        req = 2'b01; we = 2'b00; port_sel = 8'h09; IN_PORT = 8'hE7;
        step();                                   // cycle 1
        req = 2'b00;
        step();                                   // cycle 2: STROBE
`ifdef ARB_PORT_CHECK_EN
        n_checks++;
        if (READ_STROBE !== 1'b0 || WRITE_STROBE !== 1'b0) begin
            n_fail++;
            $display("FAIL port9_strobe: got rs=%b ws=%b, expected no strobe", READ_STROBE, WRITE_STROBE);
        end
`else
        n_checks++;
        if (READ_STROBE !== 1'b1 || PORT_ID !== 4'd9) begin
            n_fail++;
            $display("FAIL port9_strobe: got rs=%b PORT_ID=%h, expected 1 9", READ_STROBE, PORT_ID);
        end
`endif
        step();                                   // cycle 3: ACK
        n_checks++;
        if (ack !== 2'b01 || rdata !== (blocked(4'd9) ? 8'h00 : 8'hE7)) begin
            n_fail++;
            $display("FAIL port9_ack: got ack=%b rdata=%h, expected 01 %h", ack, rdata, blocked(4'd9) ? 8'h00 : 8'hE7);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 79) == 0);
            req      = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
            we       = 2'($urandom);
            port_sel = 8'($urandom);
            wdata    = 16'($urandom);
            IN_PORT  = 8'($urandom);
            step();
            n_checks++;
            if (PORT_ID !== exp_port_id || OUT_PORT !== exp_out) begin
                n_fail++;
                $display("FAIL rand_bus cyc=%0d: got PORT_ID=%h OUT_PORT=%h, expected %h %h", cyc, PORT_ID, OUT_PORT, exp_port_id, exp_out);
            end
            n_checks++;
            if (WRITE_STROBE !== exp_ws || READ_STROBE !== exp_rs || ack !== exp_ack) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc=%0d: got ws=%b rs=%b ack=%b, expected %b %b %b",
                         cyc, WRITE_STROBE, READ_STROBE, ack, exp_ws, exp_rs, exp_ack);
            end
            if (exp_rd_valid) begin
                n_checks++;
                if (rdata !== m_cap) begin
                    n_fail++;
                    $display("FAIL rand_rdata cyc=%0d: got %h, expected %h", cyc, rdata, m_cap);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        g_cyc       = -100;
        next_sample = 0;
        last        = 1'b1;
        win         = 1'b0;
        m_we        = 1'b0;
        m_port      = 4'd0;
        m_wd        = 8'd0;
        m_cap       = 8'd0;
        exp_port_id = 4'd0;
        exp_out     = 8'd0;
        reset       = 1'b1;
        idle_inputs();
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_reset_mid();
        test_port_check();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/port_bus_arbiter.md
PORT_BUS_ARBITER -- requirements
Module: port_bus_arbiter

Interface
REQ-001 The block SHALL have parameter STROBE_GAP, default 1: number of idle cycles inserted after each acknowledge before the next arbitration, legal range 0-7.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 2 bits: req[n] is the transaction request from master n.
REQ-005 The block SHALL have port we, input, 2 bits: we[n]=1 selects a write and we[n]=0 selects a read for master n.
REQ-006 The block SHALL have port port_sel, input, 8 bits: port_sel[4n+3:4n] is the target port for master n.
REQ-007 The block SHALL have port wdata, input, 16 bits: wdata[8n+7:8n] is the write data for master n.
REQ-008 The block SHALL have port ack, output, 2 bits: ack[n] is a one-cycle completion pulse to master n.
REQ-009 The block SHALL have port rdata, output, 8 bits: read data, valid only in the ack cycle.
REQ-010 The block SHALL have ports PORT_ID (output, 4 bits), WRITE_STROBE (output, 1 bit) and READ_STROBE (output, 1 bit): the shared port bus driving the address decoder.
REQ-011 The block SHALL have port OUT_PORT, output, 8 bits: write data to the peripherals.
REQ-012 The block SHALL have port IN_PORT, input, 8 bits: read data from the peripherals.

Function
REQ-013 The state machine SHALL have states IDLE, SETUP, STROBE, ACK and GAP.
REQ-014 In IDLE with any req bit high, the block SHALL select a winner, latch that master's we, port_sel and wdata, and go to SETUP on the next edge.
REQ-015 Arbitration SHALL be round-robin on a 1-bit last-grant pointer: on contention the master not last granted wins; an uncontested request is granted regardless of the pointer.
REQ-016 The last-grant pointer SHALL update to the winner on each grant.
REQ-017 In SETUP, PORT_ID and OUT_PORT SHALL be driven from the latched values with both strobes low, giving one cycle of address setup.
REQ-018 In STROBE, exactly one strobe SHALL be high for exactly one cycle: WRITE_STROBE if the latched we=1, READ_STROBE if the latched we=0; PORT_ID and OUT_PORT SHALL stay stable.
REQ-019 For a read, IN_PORT SHALL be registered at the end of the STROBE cycle.
REQ-020 In ACK, ack[winner] SHALL be high for one cycle and rdata SHALL hold the captured read value (0x00 for writes); the next state SHALL be GAP, or IDLE if STROBE_GAP=0.
REQ-021 GAP SHALL last STROBE_GAP cycles on a 3-bit down-counter, then return to IDLE.
REQ-022 Latency SHALL be fixed: a request sampled in IDLE at cycle 0 gives SETUP at 1, STROBE at 2 and ACK at 3.
REQ-023 Requests SHALL be sampled only in IDLE; changes to req, we, port_sel or wdata after the grant SHALL not affect the transaction in flight.
REQ-024 If a master drops req after its grant, the transaction SHALL still complete and ack SHALL still pulse.
REQ-025 A master holding req through its ack SHALL be treated as a new request at the next IDLE.
REQ-026 Outside SETUP, STROBE and ACK, PORT_ID and OUT_PORT SHALL hold their last values; strobes and ack SHALL be 0.
REQ-027 At most one ack bit and at most one strobe SHALL be high in any cycle.

Reset
REQ-028 While reset is high at a rising edge: state=IDLE, pointer=1 (so master 0 wins the first contention), GAP counter=0, and PORT_ID, OUT_PORT, rdata, ack and both strobes=0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no strobe or ack issued afterward; the aborted master must re-request.

Configuration
REQ-030 With macro ARB_PORT_CHECK_EN defined, a latched port above 7 SHALL suppress both strobes in STROBE, still pulse ack, and return rdata=0x00.
REQ-031 Without ARB_PORT_CHECK_EN, all 16 port values SHALL be strobed normally.

Verification
REQ-032 Write: req=01, we=01, port_sel[3:0]=3, wdata[7:0]=0xA5 -> PORT_ID=3 and OUT_PORT=0xA5 at cycle 1, WRITE_STROBE high at cycle 2 only, ack=01 at cycle 3.
REQ-033 Read: req=10, we=00, port_sel[7:4]=5, IN_PORT=0x3C during STROBE -> READ_STROBE high at cycle 2, ack=10 and rdata=0x3C at cycle 3.
REQ-034 Contention: req=11 held continuously after reset, STROBE_GAP=1 -> grants alternate m0, m1, m0; acks at cycles 3, 8 and 13.
REQ-035 Reset pulsed during STROBE -> strobes deasserted, no ack pulse, all outputs 0, next request completes normally.
REQ-036 ARB_PORT_CHECK_EN defined, read port 9 -> no strobe, ack pulses, rdata=0x00; macro undefined -> READ_STROBE pulses with PORT_ID=9.
